seq_game_ctrl: RTL

SEQ_GAME_CTRL -- requirements
Module: seq_game_ctrl

---
 rtl/seq_game_pkg.sv | 28 ++
 rtl/seq_game_if.sv | 28 ++
 rtl/seq_game_timer.sv | 29 ++
 rtl/seq_game_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_game_pkg.sv
// Shared types and defaults for the sequence-memory game controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_GEN_WAIT,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    typedef logic [1:0] sym_t;

    localparam int DEF_MAX_LEN    = 16;
    localparam int DEF_ON_CYCLES  = 4;
    localparam int DEF_OFF_CYCLES = 2;

    // One-hot LED pattern for a symbol.
    function automatic logic [3:0] sym2led(input sym_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/seq_game_if.sv
// Player/LFSR-facing signal bundle of the game controller.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are single-cycle pulses or levels.
interface seq_game_if;
    import seq_game_pkg::*;

    logic       start;
    logic       btn_valid;
    sym_t       btn_code;
    logic [9:0] lfsr_val;
    logic       lfsr_step;
    logic [3:0] led;
    logic [4:0] level;
    logic       busy;
    logic       win;
    logic       lose;

    modport master (
        output start, btn_valid, btn_code, lfsr_val,
        input  lfsr_step, led, level, busy, win, lose
    );

    modport slave (
        input  start, btn_valid, btn_code, lfsr_val,
        output lfsr_step, led, level, busy, win, lose
    );

endinterface

// File: rtl/seq_game_timer.sv
// Loadable down-counter timing the LED on/off phases.
// Latency: done_o is high in the cycle the count reads 1, i.e. load_val cycles after the load edge.
// Backpressure: none; a load always overrides the running count.
module seq_game_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Count down to zero and park there; a load restarts the phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/seq_game_ctrl.sv
// Sequence-memory game: grows a random symbol sequence, plays it on LEDs, checks player presses.
// Latency: all outputs registered; start reaches GEN one cycle later, a wrong press shows lose one cycle later.
// Backpressure: none; presses outside INPUT and starts during a running game are dropped.
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    seq_game_if.slave   bus
);

    localparam int IW   = $clog2(MAX_LEN);
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        st_q;
    sym_t          seq_q [MAX_LEN];
    logic [4:0]    lvl_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    led_q;
    logic          busy_q, win_q, lose_q, step_q;

    logic [4:0]    lvl_m1, idx_ext;
    logic [IW-1:0] idx_inc, wr_idx;
    logic          more, last;
    sym_t          new_sym, first_sym;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;

    // Symbols come from the two LSBs; the rest of the LFSR word is not needed.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^bus.lfsr_val[9:2];

    assign lvl_m1    = lvl_q - 5'd1;
    assign idx_ext   = 5'(idx_q);
    assign idx_inc   = idx_q + IW'(1);
    assign wr_idx    = lvl_m1[IW-1:0];
    assign more      = (idx_ext < lvl_m1);
    assign last      = (idx_ext == lvl_m1);
    assign new_sym   = bus.lfsr_val[1:0];
    // On the first round seq[0] is being written this very cycle.
    assign first_sym = (lvl_q == 5'd1) ? new_sym : seq_q[0];

    // Arm the phase timer on every entry into SHOW_ON or SHOW_OFF.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (st_q)
            S_GEN_WAIT: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(ON_CYCLES);
            end
            S_SHOW_ON: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(OFF_CYCLES);
            end
            S_SHOW_OFF: begin
                tmr_load = tmr_done && more;
                tmr_val  = TW'(ON_CYCLES);
            end
            default: ;
        endcase
    end

    seq_game_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Game FSM; outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= S_IDLE;
            lvl_q  <= '0;
            idx_q  <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            step_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
        end else begin
            case (st_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (bus.start) begin
                        lvl_q  <= 5'd1;
                        idx_q  <= '0;
                        led_q  <= '0;
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                        busy_q <= 1'b1;
                        step_q <= 1'b1;
                        st_q   <= S_GEN;
                    end
                end
                S_GEN: begin
                    step_q <= 1'b0;
                    st_q   <= S_GEN_WAIT;
                end
                S_GEN_WAIT: begin
                    seq_q[wr_idx] <= new_sym;
                    idx_q         <= '0;
                    led_q         <= sym2led(first_sym);
                    st_q          <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (tmr_done) begin
                        led_q <= '0;
                        st_q  <= S_SHOW_OFF;
                    end
                end
                S_SHOW_OFF: begin
                    if (tmr_done) begin
                        if (more) begin
                            idx_q <= idx_inc;
                            led_q <= sym2led(seq_q[idx_inc]);
                            st_q  <= S_SHOW_ON;
                        end else begin
                            idx_q  <= '0;
                            busy_q <= 1'b0;
                            st_q   <= S_INPUT;
                        end
                    end
                end
                S_INPUT: begin
                    if (bus.btn_valid) begin
                        if (bus.btn_code != seq_q[idx_q]) begin
                            lose_q <= 1'b1;
                            st_q   <= S_LOSE;
                        end else if (!last) begin
                            idx_q <= idx_inc;
                        end else if (lvl_q == 5'(MAX_LEN)) begin
                            win_q <= 1'b1;
                            led_q <= 4'b1111;
                            st_q  <= S_WIN;
                        end else begin
                            lvl_q  <= lvl_q + 5'd1;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
                            step_q <= 1'b1;
                            st_q   <= S_GEN;
                        end
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign bus.led       = led_q;
    assign bus.level     = lvl_q;
    assign bus.busy      = busy_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;
    assign bus.lfsr_step = step_q;

endmodule
